// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: table index width, update record,
// and the 2-bit saturating counter states held in the predictor table.
package bp_pkg;

  localparam int BP_IDX_W = 8;

  typedef struct packed {
    logic [BP_IDX_W-1:0] addr;
    logic                taken;
  } bp_update_t;

  typedef enum logic [1:0] {
    BP_STRONG_NT = 2'b00,
    BP_WEAK_NT   = 2'b01,
    BP_WEAK_T    = 2'b10,
    BP_STRONG_T  = 2'b11
  } bp_state_e;

  // Saturating counter step used by the table's read-modify-write
  function automatic bp_state_e bp_next_state(input bp_state_e cur, input logic taken);
    bp_state_e nxt;
    nxt = cur;
    if (taken && cur != BP_STRONG_T) begin
      nxt = bp_state_e'(cur + 2'b01);
    end else if (!taken && cur != BP_STRONG_NT) begin
      nxt = bp_state_e'(cur - 2'b01);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// In-order FIFO of predictor updates; pointers wrap naturally because DEPTH
// is a power of two. Push when full and pop when empty are ignored.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  bp_update_t                 din,
  input  logic                       pop,
  output bp_update_t                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  bp_update_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; entries are only read once count covers them
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bp_update_arbiter.sv
// Round-robin arbiter feeding branch-resolution updates from two requesters
// through a small FIFO into the predictor table's single update port.
module bp_update_arbiter
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = BP_IDX_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  input  logic [IDX_W-1:0]           req0_addr,
  input  logic                       req0_taken,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [IDX_W-1:0]           req1_addr,
  input  logic                       req1_taken,
  output logic                       req1_ready,
  input  logic                       pause,
  output logic [IDX_W-1:0]           w_addr,
  output logic                       did_branch,
  output logic                       we,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       idle
);

  logic       last_grant;
  logic       cand;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  bp_update_t push_data;
  bp_update_t head;

  // On a conflict the requester that did not win last time goes first
  assign cand       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = req0_valid && !cand && !fifo_full;
  assign req1_ready = req1_valid &&  cand && !fifo_full;
  assign push       = req0_ready || req1_ready;
  assign pop        = !fifo_empty && !pause;
  assign idle       = (count == '0) && !we;

  always_comb begin
    push_data       = '0;
    push_data.addr  = req1_ready ? req1_addr  : req0_addr;
    push_data.taken = req1_ready ? req1_taken : req0_taken;
  end

  bp_upd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      w_addr     <= '0;
      did_branch <= 1'b0;
      we         <= 1'b0;
    end else begin
      if (push) last_grant <= req1_ready;
      we <= pop;
      if (pop) begin
        w_addr     <= head.addr;
        did_branch <= head.taken;
      end
    end
  end

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Directed bench: stimulus pushes expected table writes into a queue and a
// negedge monitor pops and compares them whenever we is high.
module tb_bp_update_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid;
  logic [7:0] req0_addr;
  logic       req0_taken;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_addr;
  logic       req1_taken;
  logic       req1_ready;
  logic       pause;
  logic [7:0] w_addr;
  logic       did_branch;
  logic       we;
  logic [2:0] count;
  logic       idle;

  int         checks;
  int         failures;
  logic [8:0] exp_q[$];

  bp_update_arbiter #(
    .DEPTH(4),
    .IDX_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_taken (req0_taken),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_taken (req1_taken),
    .req1_ready (req1_ready),
    .pause      (pause),
    .w_addr     (w_addr),
    .did_branch (did_branch),
    .we         (we),
    .count      (count),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle: drive inputs just after the edge, check readiness, and queue
  // the entry that the handshake is expected to enqueue.
  task automatic applyStimulus(input logic v0, input logic [7:0] a0, input logic t0,
                               input logic v1, input logic [7:0] a1, input logic t1,
                               input logic p, input logic e0, input logic e1);
    @(posedge clk);
    #1;
    req0_valid = v0; req0_addr = a0; req0_taken = t0;
    req1_valid = v1; req1_addr = a1; req1_taken = t1;
    pause = p;
    #1;
    checkOutput("req0_ready", 32'(req0_ready), 32'(e0));
    checkOutput("req1_ready", 32'(req1_ready), 32'(e1));
    if (v0 && e0) exp_q.push_back({a0, t0});
    if (v1 && e1) exp_q.push_back({a1, t1});
  endtask

  task automatic idleCycle(input logic p);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, p, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_we actual w_addr=0x%0h expected no write at %0t", w_addr, $time);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        checkOutput("mon_w_addr", 32'(w_addr), 32'(e[8:1]));
        checkOutput("mon_did_branch", 32'(did_branch), 32'(e[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = 8'h00; req0_taken = 1'b0;
    req1_valid = 1'b0; req1_addr = 8'h00; req1_taken = 1'b0;
    pause = 1'b0;
    #2;
    checkOutput("rst_w_addr", 32'(w_addr), 32'h0);
    checkOutput("rst_we", 32'(we), 32'h0);
    checkOutput("rst_count", 32'(count), 32'h0);
    checkOutput("rst_idle", 32'(idle), 32'h1);
    doReset();

    $display("[TB] single req0 latency");
    for (int k = 0; k < 5; k++) begin
      if (k == 0) applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      else        idleCycle(1'b0);
      checkOutput("t1_we", 32'(we), 32'(k == 2));
      checkOutput("t1_idle", 32'(idle), 32'(k == 0 || k >= 3));
    end

    $display("[TB] round-robin both valid");
    doReset();
    for (int k = 0; k < 9; k++) begin
      if (k < 6) applyStimulus(1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, k % 2 == 0, k % 2 == 1);
      else       idleCycle(1'b0);
      checkOutput("t2_we", 32'(we), 32'(k >= 2 && k <= 7));
    end

    $display("[TB] pause fills fifo");
    for (int k = 0; k < 11; k++) begin
      if (k < 5) applyStimulus(1'b1, 8'hA0 + 8'(k), k[0], 1'b0, 8'h00, 1'b0, 1'b1, k < 4, 1'b0);
      else       idleCycle(1'b0);
      checkOutput("t3_we", 32'(we), 32'(k >= 6 && k <= 9));
      if (k == 4 || k == 5) checkOutput("t3_count_full", 32'(count), 32'h4);
      if (k == 9) checkOutput("t3_count_drained", 32'(count), 32'h0);
    end

    $display("[TB] full fifo with simultaneous pop");
    for (int k = 0; k < 11; k++) begin
      if (k < 4)       applyStimulus(1'b1, 8'hB0 + 8'(k), 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      else if (k == 4) applyStimulus(1'b1, 8'hC4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (k == 5) applyStimulus(1'b1, 8'hC4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      else             idleCycle(1'b0);
      if (k >= 4) checkOutput("t4_we", 32'(we), 32'(k >= 5 && k <= 9));
      if (k == 4) checkOutput("t4_count_full", 32'(count), 32'h4);
      if (k == 5 || k == 6) checkOutput("t4_count_after_pop", 32'(count), 32'h3);
      if (k == 10) checkOutput("t4_count_end", 32'(count), 32'h0);
    end

    $display("[TB] async reset mid-operation");
    for (int k = 0; k < 6; k++) begin
      if (k < 4) applyStimulus(1'b1, 8'hD0 + 8'(k), 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      else       idleCycle(1'b0);
    end
    checkOutput("t5_pre_count", 32'(count), 32'h3);
    checkOutput("t5_pre_we", 32'(we), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_async_we", 32'(we), 32'h0);
    checkOutput("t5_async_count", 32'(count), 32'h0);
    checkOutput("t5_async_w_addr", 32'(w_addr), 32'h0);
    doReset();
    for (int k = 0; k < 6; k++) begin
      idleCycle(1'b0);
      checkOutput("t5_post_we", 32'(we), 32'h0);
      checkOutput("t5_post_count", 32'(count), 32'h0);
    end

    $display("[TB] same index no merging");
    for (int k = 0; k < 6; k++) begin
      if (k < 3) applyStimulus(1'b1, 8'h55, k != 2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      else       idleCycle(1'b0);
      checkOutput("t6_we", 32'(we), 32'(k >= 2 && k <= 4));
    end

    idleCycle(1'b0);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    checkOutput("final_idle", 32'(idle), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_update_arbiter.md
Name: bp_update_arbiter

Overview:
- Sequences branch-resolution updates into the branch predictor counter table, which has a single update port (w_addr / did_branch / we).
- Accepts resolved-branch outcomes from two requesters over valid/ready handshakes: req0 is the primary branch unit, req1 is the secondary/replay path.
- Arbitrates the two requesters round-robin and buffers accepted updates in a small in-order FIFO.
- Drains one update per cycle into the table, unless paused.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- IDX_W, 8, predictor index width; must match the table index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an update.
- req0_addr  in  IDX_W  low PC bits of the resolved branch.
- req0_taken  in  1  branch was actually taken.
- req0_ready  out  1  update accepted this cycle (combinational).
- req1_valid  in  1  requester 1 has an update.
- req1_addr  in  IDX_W  low PC bits of the resolved branch.
- req1_taken  in  1  branch was actually taken.
- req1_ready  out  1  update accepted this cycle (combinational).
- pause  in  1  hold draining; enqueue continues.
- w_addr  out  IDX_W  table update index (registered).
- did_branch  out  1  table update direction (registered).
- we  out  1  table update strobe (registered).
- count  out  $clog2(DEPTH+1)  current FIFO occupancy (registered).
- idle  out  1  high when count==0 and we==0.

Behaviour:
- Clocking: one clock domain. Reset is asynchronous and active-low (rst_n), with clock port clk, matching the rest of the codebase.
- Reset values:
  - w_addr=0, did_branch=0, we=0, count=0.
  - FIFO read and write pointers = 0.
  - last_grant=1, so req0 wins the first conflict.
- A reset mid-operation discards all queued updates. No partial write is issued after reset releases.
- Arbitration and enqueue:
  - At most one enqueue per cycle.
  - Only one requester valid: that requester is the candidate.
  - Both valid: the candidate is the requester not equal to last_grant.
  - reqN_ready = candidate==N && count<DEPTH. Ready never depends on the same-cycle dequeue, so a full FIFO accepts nothing even while draining.
  - Handshake = valid && ready. On a handshake, write {addr, taken} at the write pointer, advance the pointer (wraps modulo DEPTH) and set last_grant=N.
  - last_grant is unchanged when no handshake occurs.
- Fairness:
  - A requester held valid while the other is also valid is granted within 2 accepting cycles.
  - Neither requester is ever starved while count<DEPTH.
- Dequeue:
  - When count>0 and pause==0, pop the head entry and register it: w_addr<=addr, did_branch<=taken, we<=1.
  - Otherwise we<=0. w_addr and did_branch hold their last values.
  - The read pointer wraps modulo DEPTH.
- count tracking:
  - count <= count + push - pop.
  - A simultaneous push and pop leaves count unchanged.
  - count never exceeds DEPTH and never underflows.
- Latency: a handshake in cycle 0 on an empty, unpaused FIFO gives we=1 in cycle 2 with that entry's fields.
- Throughput: with continuous traffic, we stays high every cycle, one update per cycle.
- Ordering:
  - Updates reach the table strictly in acceptance order.
  - Back-to-back updates to the same index are issued on consecutive cycles, not merged. The table's read-modify-write handles them.
- pause:
  - Takes effect on the next edge: we=0 from the following cycle.
  - Queued entries are retained.
  - Enqueue continues until the FIFO is full.
- No flow control back from the table: it accepts an update every cycle.

Decomposition:
- Shared package bp_pkg:
  - BP_IDX_W=8.
  - typedef struct packed {logic [BP_IDX_W-1:0] addr; logic taken;} bp_update_t.
  - The predictor state constants (strong/weak taken and not-taken) also belong here.
- Sub-module bp_upd_fifo: parameterised DEPTH, synchronous FIFO of bp_update_t with push/pop/full/empty/count, async active-low reset.
- The top level holds the arbiter, last_grant and the output registers.

Test Plan:
- Reset, then a single req0 (addr=0x3C, taken=1) in cycle 0 -> req0_ready=1 in cycle 0; we=1, w_addr=0x3C, did_branch=1 in cycle 2 only; idle=1 from cycle 3.
- Both requesters continuously valid (req0 addr=0x10, req1 addr=0x20) -> grants alternate 0,1,0,1; the we stream shows w_addr 0x10, 0x20, 0x10, 0x20 with no gaps.
- pause=1, push 5 updates -> 4 accepted, count=4, 5th requester ready=0. Drop pause -> 4 consecutive we pulses in order, then count=0.
- Full FIFO with simultaneous pop (pause=0, count=4) -> ready=0 that cycle, count=3 next cycle; ready=1 the cycle after.
- Assert rst_n=0 with count=3 and we=1 -> we=0 and count=0 immediately (async). After release, no stale updates are issued.
- Same index 0x55 pushed 3 times, taken=1,1,0 -> three consecutive we pulses with did_branch 1,1,0, no merging.
